multdiv_issue: RTL
==================

Name: multdiv_issue

Overview:
- Execute-stage controller directly upstream of the multicycle mult/div unit.
- Accepts a mult/div op from the EX pipeline register, latches its operands and holds them stable while the unit runs.
- Stalls the pipeline until the result is ready, then captures the result and holds it until the pipeline advances.
- Owns flush/reset sequencing toward the unit.

Parameters:
WIDTH, 64, operand/result width (u64 in the codebase).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  EX holds a mult/div instruction
in_a  in  WIDTH  rs1 operand
in_b  in  WIDTH  rs2 operand
in_type  in  mult_t  operation
flush  in  1  pipeline flush
ex_advance  in  1  EX stage moves forward this cycle
stall  out  1  hold EX/earlier stages
result  out  WIDTH  final result (already W-sign-extended by the unit)
result_valid  out  1  result is valid for the current instruction
mc_a  out  WIDTH  operand a to the multicycle unit
mc_b  out  WIDTH  operand b to the multicycle unit
mc_type  out  mult_t  op type to the multicycle unit
mc_is_multdiv  out  1  start pulse to the multicycle unit
mc_flush  out  1  abort to the multicycle unit
mc_c  in  WIDTH  result from the multicycle unit
mc_ok  in  1  unit idle/finishing (combinational state_nxt==INIT)

Behaviour:
- Reset (async, any state): state=IDLE; a_q, b_q, res_q = 0; type_q = MULT_MUL.
  - Outputs at reset: stall=0, result_valid=0, result=0, mc_is_multdiv=0, mc_a=0, mc_b=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_valid=1: latch in_a/in_b/in_type into a_q/b_q/type_q; go ISSUE; stall=1 (combinational, same cycle).
  - in_valid=0: stay IDLE; stall=0.
- ISSUE (exactly 1 cycle): mc_is_multdiv=1; go WAIT; stall=1.
- WAIT:
  - stall=1; mc_is_multdiv=0.
  - The cycle the unit enters DOING, mc_ok=0.
  - The first cycle with mc_ok=1: capture mc_c into res_q; go DONE.
- DONE:
  - stall=0; result_valid=1; result=res_q.
  - ex_advance=1: go IDLE.
  - ex_advance=0: hold DONE and res_q indefinitely. in_valid stays high for the same instruction and must not re-issue.
- mc_a/mc_b/mc_type are always driven from a_q/b_q/type_q, so they are stable from ISSUE through DONE.
- result=res_q in all states; result_valid gates its use.
- Latency from IDLE acceptance to result_valid, at the current unit delays:
  - MUL/MULW: 4 cycles.
  - DIV/REM family: 68 cycles.
  - No fixed latency is assumed; the controller always waits for mc_ok.
- flush:
  - Any state goes to IDLE next cycle; mc_flush=flush combinationally.
  - In-flight result is discarded and res_q is not updated.
  - Flush has priority over in_valid, mc_ok and ex_advance in the same cycle.
- Reset mid-operation: IDLE immediately; the unit is reset in parallel by its own reset.
- Non-mult/div types on in_type while in_valid: treated as a decoder error; FSM still issues. The verification assertion flags it.

Optional Feature:
MULTDIV_REUSE_EN
- With it: a one-entry cache holds {type, a, b, result, valid}, written in WAIT when the result is captured.
  - In IDLE, in_valid with exact match on type/a/b and valid=1: load res_q from the cache and go straight to DONE. Result_valid follows 1 cycle after acceptance, stall=1 for that one cycle, no mc_is_multdiv pulse.
  - Cache valid is cleared by reset only. Flush leaves it intact, since the cached value is a pure function of type/a/b.
- Without it: no cache; every op issues.

Decomposition:
- Shared package holds:
  - mult_t (existing), which includes MULT_MUL..MULT_REMUW.
  - A new issue_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - An is_multdiv_type() helper function.
- One sub-module is natural: multdiv_reuse_cache, the one-entry compare/store, instantiated only under MULTDIV_REUSE_EN.

Test Plan:
- MUL a=6 b=7, ex_advance=1:
  - mc_is_multdiv pulses once, 1 cycle after acceptance.
  - result_valid=1 with result=42 exactly 4 cycles after acceptance.
  - stall=1 on cycles 0..3, then stall=0.
- DIVU a=100 b=7:
  - result=14 after 68 cycles; stall held throughout.
  - mc_a/mc_b remain 100/7 every WAIT cycle.
- DIVW a=0xFFFF_FFFF_FFFF_FFF0 (-16) b=3:
  - result=0xFFFF_FFFF_FFFF_FFFB (-5).
  - ex_advance=0 for 3 cycles: DONE and result are held and there is no second mc_is_multdiv.
- DIV started, flush at WAIT cycle 10:
  - mc_flush=1 that cycle; IDLE next cycle; result_valid never asserts.
  - A following MUL 3*5 returns 15 normally.
- Async reset asserted mid-WAIT (not on a clock edge): stall, result_valid and mc_is_multdiv go 0 immediately; state is IDLE after release.
- MULTDIV_REUSE_EN: REMU 17,5 -> 2, then the identical REMU 17,5.
  - Second op returns 2 one cycle after acceptance with no mc_is_multdiv.
  - REMU 17,6 then issues normally and returns 5.

Source files
------------

// File: rtl/multdiv_issue_pkg.sv
// ============================================================================
// multdiv_issue_pkg: shared op/state types for the mult/div issue controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package multdiv_issue_pkg;

    localparam int unsigned C_DEFAULT_WIDTH = 64;

    typedef enum logic [3:0] {
        MULT_MUL    = 4'd0,
        MULT_MULH   = 4'd1,
        MULT_MULHSU = 4'd2,
        MULT_MULHU  = 4'd3,
        MULT_MULW   = 4'd4,
        MULT_DIV    = 4'd5,
        MULT_DIVU   = 4'd6,
        MULT_REM    = 4'd7,
        MULT_REMU   = 4'd8,
        MULT_DIVW   = 4'd9,
        MULT_DIVUW  = 4'd10,
        MULT_REMW   = 4'd11,
        MULT_REMUW  = 4'd12
    } mult_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } issue_state_t;

    // Encodings above MULT_REMUW are decoder garbage, not real ops.
    function automatic logic is_multdiv_type(input mult_t t);
        return (t <= MULT_REMUW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_issue_if.sv
// ============================================================================
// multdiv_issue_if: operand/result bus between issue controller and unit.
// Rev 1.0
// ============================================================================
`default_nettype none

interface multdiv_issue_if
    import multdiv_issue_pkg::*;
#(
    parameter int WIDTH = 64
) ();

    logic [WIDTH-1:0] mc_a;
    logic [WIDTH-1:0] mc_b;
    mult_t            mc_type;
    logic             mc_is_multdiv;
    logic             mc_flush;
    logic [WIDTH-1:0] mc_c;
    logic             mc_ok;

    modport master (
        output mc_a,
        output mc_b,
        output mc_type,
        output mc_is_multdiv,
        output mc_flush,
        input  mc_c,
        input  mc_ok
    );

    modport slave (
        input  mc_a,
        input  mc_b,
        input  mc_type,
        input  mc_is_multdiv,
        input  mc_flush,
        output mc_c,
        output mc_ok
    );

endinterface

`default_nettype wire

// File: rtl/multdiv_issue_reuse_cache.sv
// ============================================================================
// multdiv_reuse_cache: one-entry {type,a,b} -> result store with exact match.
// Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_reuse_cache
    import multdiv_issue_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  mult_t            wr_type,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [WIDTH-1:0] wr_res,
    input  mult_t            lk_type,
    input  logic [WIDTH-1:0] lk_a,
    input  logic [WIDTH-1:0] lk_b,
    output logic             hit,
    output logic [WIDTH-1:0] hit_res
);

    logic             r_valid;
    mult_t            r_type;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;

    // Entry is a pure function of its key, so only reset invalidates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_type  <= MULT_MUL;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_type  <= wr_type;
            r_a     <= wr_a;
            r_b     <= wr_b;
            r_res   <= wr_res;
        end
    end

    assign hit     = r_valid && (lk_type == r_type) && (lk_a == r_a) && (lk_b == r_b);
    assign hit_res = r_res;

endmodule

`default_nettype wire

// File: rtl/multdiv_issue.sv
// ============================================================================
// multdiv_issue: EX-stage issue/stall/flush controller for the multicycle
// mult/div unit. Optional MULTDIV_REUSE_EN adds a one-entry result cache.
// Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_issue
    import multdiv_issue_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  mult_t             in_type,
    input  logic              flush,
    input  logic              ex_advance,
    output logic              stall,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    multdiv_issue_if.master   mc
);

    issue_state_t     r_state;
    issue_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    mult_t            r_type;
    logic [WIDTH-1:0] r_res;

    logic             w_latch;
    logic             w_issue;
    logic             w_capture;
    logic             w_load_hit;
    logic             w_hit;
    logic [WIDTH-1:0] w_hit_res;

`ifdef MULTDIV_REUSE_EN
    multdiv_reuse_cache #(
        .WIDTH   (WIDTH)
    ) u_reuse_cache (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_capture),
        .wr_type (r_type),
        .wr_a    (r_a),
        .wr_b    (r_b),
        .wr_res  (mc.mc_c),
        .lk_type (in_type),
        .lk_a    (in_a),
        .lk_b    (in_b),
        .hit     (w_hit),
        .hit_res (w_hit_res)
    );
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        stall        = 1'b0;
        result_valid = 1'b0;
        w_latch      = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_load_hit   = 1'b0;

        case (r_state)
            IDLE: begin
                // reset gating keeps stall low while async reset is held
                if (in_valid && !reset && !flush) begin
                    stall   = 1'b1;
                    w_latch = 1'b1;
                    if (w_hit) begin
                        w_load_hit  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall       = 1'b1;
                w_issue     = !flush;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mc.mc_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (ex_advance) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Flush beats every other same-cycle event and drops any in-flight result.
        if (flush) begin
            w_state_nxt = IDLE;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_type  <= MULT_MUL;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_type <= in_type;
            end
            if (w_capture) begin
                r_res <= mc.mc_c;
            end else if (w_load_hit) begin
                r_res <= w_hit_res;
            end
        end
    end

    assign mc.mc_a          = r_a;
    assign mc.mc_b          = r_b;
    assign mc.mc_type       = r_type;
    assign mc.mc_is_multdiv = w_issue;
    assign mc.mc_flush      = flush;
    assign result           = r_res;

    // Garbage op types still issue; this only flags the decoder fault.
    a_legal_type: assert property (@(posedge clk) disable iff (reset)
        (r_state == IDLE && in_valid && !flush) |-> is_multdiv_type(in_type));

endmodule

`default_nettype wire
